// File: rtl/frame_config_mem_buffered_if.sv
// Bus bundle for frame_config_mem_buffered.
// The master drives frame writes, commit, readback requests and error clear.
// The slave (the memory) returns readback data, status flags and the active config vector.
//   frame_data/frame_strobe : frame word and its one-hot write select
//   commit                  : copy all shadow frames into the active frames
//   read_req/read_shadow/read_sel : readback request, bank select, frame index
//   err_clear               : clears the sticky strobe error
//   read_data/read_valid    : readback word and its one-cycle valid pulse
//   pending/strobe_err      : uncommitted writes exist / multi-hot strobe seen
//   config_bits             : active configuration export
interface frame_config_mem_buffered_if #(
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned NoConfigBits    = 640,
    parameter int unsigned FrameSelW       = 5
);
    logic [FrameBitsPerRow-1:0] frame_data;
    logic [MaxFramesPerCol-1:0] frame_strobe;
    logic                       commit;
    logic                       read_req;
    logic                       read_shadow;
    logic [FrameSelW-1:0]       read_sel;
    logic                       err_clear;
    logic [FrameBitsPerRow-1:0] read_data;
    logic                       read_valid;
    logic                       pending;
    logic                       strobe_err;
    logic [NoConfigBits-1:0]    config_bits;

    modport master (
        output frame_data, frame_strobe, commit, read_req, read_shadow, read_sel, err_clear,
        input  read_data, read_valid, pending, strobe_err, config_bits
    );

    modport slave (
        input  frame_data, frame_strobe, commit, read_req, read_shadow, read_sel, err_clear,
        output read_data, read_valid, pending, strobe_err, config_bits
    );
endinterface

// File: rtl/frame_config_mem_buffered.sv
// Double-buffered configuration memory for one fabric tile.
// Frames are written into shadow registers via a one-hot strobe; a commit copies every
// shadow frame into the active registers that drive config_bits. Provides a one-cycle
// latency readback of either bank and a sticky multi-hot strobe error flag.
// Ports:
//   clk : config clock, all state updates on the rising edge
//   rst : asynchronous active-high reset, clears all frames and flags
//   bus : slave side of frame_config_mem_buffered_if (see interface file for signals)
module frame_config_mem_buffered #(
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned NoConfigBits    = 640,
    parameter int unsigned FrameSelW       = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    frame_config_mem_buffered_if.slave    bus
);
    localparam int unsigned TotalBits = MaxFramesPerCol * FrameBitsPerRow;

    logic [FrameBitsPerRow-1:0] shadow_q [MaxFramesPerCol];
    logic [FrameBitsPerRow-1:0] shadow_d [MaxFramesPerCol];
    logic [FrameBitsPerRow-1:0] active_q [MaxFramesPerCol];
    logic [FrameBitsPerRow-1:0] active_d [MaxFramesPerCol];
    logic [MaxFramesPerCol-1:0] dirty_q, dirty_d;
    logic [FrameBitsPerRow-1:0] read_data_q, read_data_d;
    logic                       read_valid_q, read_valid_d;
    logic                       strobe_err_q, strobe_err_d;

    logic                       strobe_any;
    logic                       strobe_multi;
    logic [TotalBits-1:0]       active_flat;

    // Clearing the lowest set bit leaves something only when more than one bit is set.
    assign strobe_any   = |bus.frame_strobe;
    assign strobe_multi = |(bus.frame_strobe & (bus.frame_strobe - MaxFramesPerCol'(1)));

    always_comb begin
        shadow_d = shadow_q;
        dirty_d  = bus.commit ? '0 : dirty_q;
        // Commit captures pre-edge shadow values, so a same-edge write lands only in shadow.
        active_d = bus.commit ? shadow_q : active_q;
        if (strobe_any && !strobe_multi) begin
            for (int unsigned f = 0; f < MaxFramesPerCol; f++) begin
                if (bus.frame_strobe[f]) begin
                    shadow_d[f] = bus.frame_data;
                    dirty_d[f]  = 1'b1;
                end
            end
        end
    end

    assign strobe_err_d = strobe_multi | (strobe_err_q & ~bus.err_clear);

    // Readback of pre-edge state; an out-of-range index matches no frame and returns zero.
    always_comb begin
        read_data_d  = read_data_q;
        read_valid_d = bus.read_req;
        if (bus.read_req) begin
            read_data_d = '0;
            for (int unsigned f = 0; f < MaxFramesPerCol; f++) begin
                if (32'(bus.read_sel) == f) begin
                    read_data_d = bus.read_shadow ? shadow_q[f] : active_q[f];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q     <= '{default: '0};
            active_q     <= '{default: '0};
            dirty_q      <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            strobe_err_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            dirty_q      <= dirty_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            strobe_err_q <= strobe_err_d;
        end
    end

    always_comb begin
        active_flat = '0;
        for (int unsigned f = 0; f < MaxFramesPerCol; f++) begin
            active_flat[f*FrameBitsPerRow +: FrameBitsPerRow] = active_q[f];
        end
    end

    assign bus.config_bits = active_flat[NoConfigBits-1:0];
    assign bus.pending     = |dirty_q;
    assign bus.strobe_err  = strobe_err_q;
    assign bus.read_data   = read_data_q;
    assign bus.read_valid  = read_valid_q;
endmodule
